// File: rtl/december_pkg.sv
// Shared constants and encodings for the SAT-solver datapath top level.
// Address decode lives here so the write and read paths agree on the map.
package december_pkg;

    localparam logic [31:0] ATT_BASE    = 32'h0000_0000;
    localparam logic [31:0] CLAUSE_BASE = 32'h0000_4000;
    localparam logic [31:0] REGION_MASK = 32'h0000_4000;
    localparam logic [31:0] MAP_LIMIT   = 32'h0000_8000;

    localparam int unsigned WORD_IDX_W = 12;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WIdle = 2'b00,
        WData = 2'b01,
        WResp = 2'b10
    } w_state_e;

    typedef enum logic [1:0] {
        RIdle  = 2'b00,
        RFetch = 2'b01,
        RData  = 2'b10
    } r_state_e;

    typedef enum logic [1:0] {
        SolveIdle = 2'b00,
        SolveScan = 2'b01,
        SolveDone = 2'b10
    } solve_state_e;

    typedef enum logic [1:0] {
        RegionAtt,
        RegionClause,
        RegionNone
    } region_e;

    function automatic region_e addr_region(logic [31:0] addr);
        if (addr >= MAP_LIMIT) begin
            return RegionNone;
        end else if ((addr & REGION_MASK) == ATT_BASE) begin
            return RegionAtt;
        end else begin
            return RegionClause;
        end
    endfunction

endpackage

// File: rtl/december_solver_ctrl.sv
// Solver controller: on a start edge, walks every clause row once, then parks in DONE.
// Status is exported as {state, clause_idx}.
module december_solver_ctrl
    import december_pkg::*;
#(
    parameter int unsigned NumClauses = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        scan_rd_en_o,
    output logic [11:0] scan_idx_o,
    output logic [13:0] control_signal_o,
    output logic        done_o
);

    localparam logic [11:0] LastIdx = 12'(NumClauses - 1);

    solve_state_e state_q, state_d;
    logic [11:0]  idx_q, idx_d;
    logic         start_q, start_prev_q;
    logic         start_edge;

    // start_i is registered first, so the edge acts one cycle after it is sampled.
    assign start_edge = start_q & ~start_prev_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            SolveIdle, SolveDone: begin
                if (start_edge) begin
                    state_d = SolveScan;
                    idx_d   = '0;
                end
            end
            SolveScan: begin
                if (idx_q == LastIdx) begin
                    state_d = SolveDone;
                end else begin
                    idx_d = idx_q + 12'd1;
                end
            end
            default: begin
                state_d = SolveIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= SolveIdle;
            idx_q        <= '0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            start_q      <= start_i;
            start_prev_q <= start_q;
        end
    end

    assign scan_rd_en_o     = (state_q == SolveScan);
    assign scan_idx_o       = idx_q;
    assign control_signal_o = {state_q, idx_q};
    assign done_o           = (state_q == SolveDone);

endmodule

// File: rtl/december_top_file.sv
// AXI4 slave front-end for the ATT and Clause Table, plus the clause-scan controller.
// Write and read channels run as independent FSMs; every access is one 32-bit word.
module december_top_file
    import december_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int unsigned NUM_CLAUSES    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      done_signal,
    output logic [13:0]               control_signal_i,

    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int unsigned Words = 1 << WORD_IDX_W;

    logic [AXI_DATA_WIDTH-1:0] att_mem    [Words];
    logic [AXI_DATA_WIDTH-1:0] clause_mem [Words];

    // Keeps awready/arready low until the first clock after reset release.
    logic out_en_q;

    w_state_e                  w_state_q, w_state_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [AXI_ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [7:0]                aw_len_q, aw_len_d;
    logic [7:0]                w_cnt_q, w_cnt_d;
    logic                      w_err_q, w_err_d;
    region_e                   w_region;
    logic                      att_we, clause_we;
    logic [WORD_IDX_W-1:0]     w_idx;

    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [AXI_ID_WIDTH-1:0]   ar_id_q, ar_id_d;
    logic [7:0]                ar_len_q, ar_len_d;
    logic [7:0]                r_cnt_q, r_cnt_d;
    region_e                   r_region;
    logic                      rd_fetch;
    logic [WORD_IDX_W-1:0]     r_idx;
    logic [AXI_DATA_WIDTH-1:0] att_rd_q, clause_rd_q;

    logic                      scan_rd_en;
    logic [11:0]               scan_idx;
    logic [AXI_DATA_WIDTH-1:0] scan_row_q;

    assign w_region = addr_region(32'(aw_addr_q));
    assign w_idx    = aw_addr_q[WORD_IDX_W+1:2];
    assign r_region = addr_region(32'(ar_addr_q));
    assign r_idx    = ar_addr_q[WORD_IDX_W+1:2];

    // Write channel
    always_comb begin
        w_state_d     = w_state_q;
        aw_addr_d     = aw_addr_q;
        aw_id_d       = aw_id_q;
        aw_len_d      = aw_len_q;
        w_cnt_d       = w_cnt_q;
        w_err_d       = w_err_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        att_we        = 1'b0;
        clause_we     = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                s_axi_awready = out_en_q;
                if (out_en_q && s_axi_awvalid) begin
                    aw_addr_d = s_axi_awaddr;
                    aw_id_d   = s_axi_awid;
                    aw_len_d  = s_axi_awlen;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    att_we    = (w_region == RegionAtt);
                    clause_we = (w_region == RegionClause);
                    w_err_d   = w_err_q | (w_region == RegionNone);
                    aw_addr_d = aw_addr_q + AXI_ADDR_WIDTH'(4);
                    if (w_cnt_q == aw_len_q) begin
                        w_state_d = WResp;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                    end
                end
            end
            WResp: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    assign s_axi_bid   = aw_id_q;
    assign s_axi_bresp = w_err_q ? RESP_SLVERR : RESP_OKAY;

    // Read channel
    always_comb begin
        r_state_d     = r_state_q;
        ar_addr_d     = ar_addr_q;
        ar_id_d       = ar_id_q;
        ar_len_d      = ar_len_q;
        r_cnt_d       = r_cnt_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        rd_fetch      = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                s_axi_arready = out_en_q;
                if (out_en_q && s_axi_arvalid) begin
                    ar_addr_d = s_axi_araddr;
                    ar_id_d   = s_axi_arid;
                    ar_len_d  = s_axi_arlen;
                    r_cnt_d   = '0;
                    r_state_d = RFetch;
                end
            end
            RFetch: begin
                rd_fetch  = 1'b1;
                r_state_d = RData;
            end
            RData: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    if (r_cnt_q == ar_len_q) begin
                        r_state_d = RIdle;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        ar_addr_d = ar_addr_q + AXI_ADDR_WIDTH'(4);
                        r_state_d = RFetch;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        s_axi_rdata = '0;
        unique case (r_region)
            RegionAtt:    s_axi_rdata = att_rd_q;
            RegionClause: s_axi_rdata = clause_rd_q;
            default:      s_axi_rdata = '0;
        endcase
    end

    assign s_axi_rid   = ar_id_q;
    assign s_axi_rresp = (r_region == RegionNone) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast = (r_cnt_q == ar_len_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_en_q  <= 1'b0;
            w_state_q <= WIdle;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            aw_len_q  <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= RIdle;
            ar_addr_q <= '0;
            ar_id_q   <= '0;
            ar_len_q  <= '0;
            r_cnt_q   <= '0;
        end else begin
            out_en_q  <= 1'b1;
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            aw_id_q   <= aw_id_d;
            aw_len_q  <= aw_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            ar_id_q   <= ar_id_d;
            ar_len_q  <= ar_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Read registers only load in RFetch so rdata holds while the master stalls.
    always_ff @(posedge clk_i) begin
        if (att_we) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) att_mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
        if (rd_fetch) begin
            att_rd_q <= att_mem[r_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (clause_we) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) clause_mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
        if (rd_fetch) begin
            clause_rd_q <= clause_mem[r_idx];
        end
        if (scan_rd_en) begin
            scan_row_q <= clause_mem[scan_idx];
        end
    end

    december_solver_ctrl #(
        .NumClauses (NUM_CLAUSES)
    ) u_solver_ctrl (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .scan_rd_en_o     (scan_rd_en),
        .scan_idx_o       (scan_idx),
        .control_signal_o (control_signal_i),
        .done_o           (done_signal)
    );

    // Scanned rows feed the downstream clause evaluator; sizes/bursts are fixed by design.
    logic unused_inputs;
    assign unused_inputs = ^{scan_row_q, s_axi_awsize, s_axi_awburst, s_axi_arsize,
                             s_axi_arburst, s_axi_wlast};

endmodule

// File: tb/tb_december_top_file.sv
// Scoreboard bench: stimulus pushes expected B/R responses, a negedge monitor pops and compares.
module tb_december_top_file;

    localparam int Timeout = 200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        done_signal;
    logic [13:0] control_signal_i;

    logic [3:0]  s_axi_awid = '0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'd2;
    logic [1:0]  s_axi_awburst = 2'b01;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [3:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    logic [31:0] exp_rdata [8];
    logic [1:0]  exp_rresp [8];

    int n_checks = 0;
    int n_fail   = 0;

    december_top_file #(
        .AXI_ID_WIDTH   (4),
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .AXI_STRB_WIDTH (4),
        .NUM_CLAUSES    (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .done_signal      (done_signal),
        .control_signal_i (control_signal_i),
        .s_axi_awid       (s_axi_awid),
        .s_axi_awaddr     (s_axi_awaddr),
        .s_axi_awlen      (s_axi_awlen),
        .s_axi_awsize     (s_axi_awsize),
        .s_axi_awburst    (s_axi_awburst),
        .s_axi_awvalid    (s_axi_awvalid),
        .s_axi_awready    (s_axi_awready),
        .s_axi_wdata      (s_axi_wdata),
        .s_axi_wstrb      (s_axi_wstrb),
        .s_axi_wlast      (s_axi_wlast),
        .s_axi_wvalid     (s_axi_wvalid),
        .s_axi_wready     (s_axi_wready),
        .s_axi_bid        (s_axi_bid),
        .s_axi_bresp      (s_axi_bresp),
        .s_axi_bvalid     (s_axi_bvalid),
        .s_axi_bready     (s_axi_bready),
        .s_axi_arid       (s_axi_arid),
        .s_axi_araddr     (s_axi_araddr),
        .s_axi_arlen      (s_axi_arlen),
        .s_axi_arsize     (s_axi_arsize),
        .s_axi_arburst    (s_axi_arburst),
        .s_axi_arvalid    (s_axi_arvalid),
        .s_axi_arready    (s_axi_arready),
        .s_axi_rid        (s_axi_rid),
        .s_axi_rdata      (s_axi_rdata),
        .s_axi_rresp      (s_axi_rresp),
        .s_axi_rlast      (s_axi_rlast),
        .s_axi_rvalid     (s_axi_rvalid),
        .s_axi_rready     (s_axi_rready)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake never happened within %0d cycles", name, Timeout);
    endtask

    // Monitor: pops on each completed B/R handshake; a stalled R beat must match the queue head.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) begin
                    timeout_fail("b_unexpected");
                end else begin
                    b_exp_t e;
                    e = bq.pop_front();
                    check("b_id_resp", 64'({s_axi_bid, s_axi_bresp}), 64'({e.id, e.resp}));
                end
            end
            if (s_axi_rvalid) begin
                if (rq.size() == 0) begin
                    timeout_fail("r_unexpected");
                end else if (s_axi_rready) begin
                    r_exp_t e;
                    e = rq.pop_front();
                    check("r_beat", 64'({s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata}),
                          64'({e.id, e.resp, e.last, e.data}));
                end else begin
                    check("r_hold", 64'(s_axi_rdata), 64'(rq[0].data));
                end
            end
        end
    end

    task automatic drain();
        int t = 0;
        while ((bq.size() != 0 || rq.size() != 0) && t < Timeout) begin
            @(negedge clk_i);
            t++;
        end
        if (t == Timeout) timeout_fail("drain");
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [3:0] strb, input logic [31:0] data0, input bit extra,
                             input logic [1:0] exp_resp);
        int t;
        bq.push_back('{id: id, resp: exp_resp});
        s_axi_awaddr  = addr;
        s_axi_awid    = id;
        s_axi_awlen   = len;
        s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < Timeout) begin
            @(negedge clk_i);
            t++;
        end
        if (t == Timeout) timeout_fail("aw_handshake");
        @(negedge clk_i);
        s_axi_awvalid = 1'b0;
        check("w_ready_after_aw", 64'(s_axi_wready), 64'(1));
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata  = data0 + 32'(i);
            s_axi_wstrb  = strb;
            s_axi_wlast  = (i == int'(len));
            s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < Timeout) begin
                @(negedge clk_i);
                t++;
            end
            if (t == Timeout) timeout_fail("w_handshake");
            @(negedge clk_i);
        end
        if (extra) begin
            s_axi_wdata = 32'h0000_0055;
            s_axi_wstrb = 4'hF;
            @(negedge clk_i);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        drain();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input int stall);
        int t;
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back('{id: id, data: exp_rdata[i], resp: exp_rresp[i], last: (i == int'(len))});
        end
        if (stall > 0) s_axi_rready = 1'b0;
        s_axi_araddr  = addr;
        s_axi_arid    = id;
        s_axi_arlen   = len;
        s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < Timeout) begin
            @(negedge clk_i);
            t++;
        end
        if (t == Timeout) timeout_fail("ar_handshake");
        @(negedge clk_i);
        s_axi_arvalid = 1'b0;
        check("r_lat_fetch", 64'(s_axi_rvalid), 64'(0));
        @(negedge clk_i);
        check("r_lat_data", 64'(s_axi_rvalid), 64'(1));
        if (stall > 0) begin
            repeat (stall) @(negedge clk_i);
            @(posedge clk_i);
            #1 s_axi_rready = 1'b1;
        end
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_awready", 64'(s_axi_awready), 64'(0));
        check("rst_arready", 64'(s_axi_arready), 64'(0));
        check("rst_wready", 64'(s_axi_wready), 64'(0));
        check("rst_bvalid", 64'(s_axi_bvalid), 64'(0));
        check("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check("rst_done", 64'(done_signal), 64'(0));
        check("rst_control", 64'(control_signal_i), 64'(0));
        rst_i = 1'b1;
        #1 check("awready_at_release", 64'(s_axi_awready), 64'(0));
        @(negedge clk_i);
        check("awready_first_clk", 64'(s_axi_awready), 64'(1));
        check("arready_first_clk", 64'(s_axi_arready), 64'(1));

        // ATT single write/read
        axi_write(32'h0000_0000, 4'd2, 8'd0, 4'hF, 32'h0000_0001, 1'b0, 2'b00);
        exp_rdata[0] = 32'h0000_0001; exp_rresp[0] = 2'b00;
        axi_read(32'h0000_0000, 4'd2, 8'd0, 0);

        // Clause table, rewrite, no aliasing with ATT
        axi_write(32'h0000_4000, 4'd1, 8'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2'b00);
        exp_rdata[0] = 32'hDEAD_BEEF; exp_rresp[0] = 2'b00;
        axi_read(32'h0000_4000, 4'd1, 8'd0, 0);
        axi_write(32'h0000_4000, 4'd3, 8'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2'b00);
        axi_read(32'h0000_4000, 4'd3, 8'd0, 0);
        exp_rdata[0] = 32'h0000_0001;
        axi_read(32'h0000_0000, 4'd4, 8'd0, 0);

        // Byte strobes, read back with a stalled rready
        axi_write(32'h0000_4004, 4'd5, 8'd0, 4'hF, 32'hFFFF_FFFF, 1'b0, 2'b00);
        axi_write(32'h0000_4004, 4'd5, 8'd0, 4'b0011, 32'h1234_5678, 1'b0, 2'b00);
        exp_rdata[0] = 32'hFFFF_5678; exp_rresp[0] = 2'b00;
        axi_read(32'h0000_4004, 4'd6, 8'd0, 3);

        // 4-beat INCR burst; the trailing wvalid must not reach word 0x20
        axi_write(32'h0000_0020, 4'd7, 8'd0, 4'hF, 32'hA5A5_A5A5, 1'b0, 2'b00);
        axi_write(32'h0000_0010, 4'd8, 8'd3, 4'hF, 32'h0000_0001, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            exp_rdata[i] = 32'(i + 1);
            exp_rresp[i] = 2'b00;
        end
        axi_read(32'h0000_0010, 4'd9, 8'd3, 0);
        exp_rdata[0] = 32'hA5A5_A5A5; exp_rresp[0] = 2'b00;
        axi_read(32'h0000_0020, 4'd9, 8'd0, 0);

        // Unmapped region
        axi_write(32'h0000_8000, 4'd10, 8'd0, 4'hF, 32'h1111_2222, 1'b0, 2'b10);
        exp_rdata[0] = 32'h0; exp_rresp[0] = 2'b10;
        axi_read(32'h0000_8000, 4'd11, 8'd0, 0);

        // Burst crossing from the last clause word into unmapped space
        axi_write(32'h0000_7FFC, 4'd12, 8'd1, 4'hF, 32'h0BAD_F00D, 1'b0, 2'b10);
        exp_rdata[0] = 32'h0BAD_F00D; exp_rresp[0] = 2'b00;
        exp_rdata[1] = 32'h0;         exp_rresp[1] = 2'b10;
        axi_read(32'h0000_7FFC, 4'd13, 8'd1, 0);

        // Solver: single pulse, 16-row scan, done 17 cycles after start is sampled
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("solve_still_idle", 64'(control_signal_i), 64'(0));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            check("solve_scan_status", 64'(control_signal_i), 64'({2'b01, 12'(i)}));
            check("solve_not_done", 64'(done_signal), 64'(0));
        end
        @(negedge clk_i);
        check("solve_done", 64'(done_signal), 64'(1));
        check("solve_done_state", 64'(control_signal_i[13:12]), 64'(2'b10));

        // Held-high start runs once and then stays done
        start_i = 1'b1;
        repeat (25) @(negedge clk_i);
        check("held_start_done", 64'(done_signal), 64'(1));
        check("held_start_state", 64'(control_signal_i[13:12]), 64'(2'b10));
        start_i = 1'b0;

        // Start edge during SCAN is ignored
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (11) @(negedge clk_i);
        check("retrigger_ignored_idx", 64'(control_signal_i), 64'({2'b01, 12'd15}));
        @(negedge clk_i);
        check("retrigger_ignored_done", 64'(done_signal), 64'(1));

        // Reset mid-SCAN
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (6) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("midscan_rst_done", 64'(done_signal), 64'(0));
        check("midscan_rst_control", 64'(control_signal_i), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Memories survive reset
        exp_rdata[0] = 32'h0000_0001; exp_rresp[0] = 2'b00;
        axi_read(32'h0000_0000, 4'd14, 8'd0, 0);

        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
